// File: rtl/usb_tx_pkg.sv
// Shared constants, command/state types and helpers for the USB FS transmitter.
package usb_tx_pkg;

  localparam int CLKS_PER_BIT = 8;
  localparam int PHASE_W      = $clog2(CLKS_PER_BIT);
  localparam int MAX_BYTES    = 64;
  localparam int STUFF_RUN    = 6;

  // tx_packet command encodings
  localparam logic [1:0] CMD_IDLE = 2'b00;
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_ACK  = 2'b10;
  localparam logic [1:0] CMD_NAK  = 2'b11;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_DATA0 = 8'hC3;

  localparam logic [15:0] CRC_POLY = 16'h8005;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_CRC, ST_EOP_SE0, ST_EOP_J, ST_REARM
  } tx_state_t;

  typedef struct packed {
    logic [1:0] pkt;
    logic [6:0] size;
  } tx_cmd_t;

  function automatic logic [7:0] pid_for(input logic [1:0] pkt);
    case (pkt)
      CMD_ACK: pid_for = PID_ACK;
      CMD_NAK: pid_for = PID_NAK;
      default: pid_for = PID_DATA0;
    endcase
  endfunction

  // Complemented remainder, reordered so bit 0 (sent first) is the x^15 term.
  function automatic logic [15:0] crc_tx_bits(input logic [15:0] rem);
    for (int i = 0; i < 16; i++) crc_tx_bits[i] = ~rem[15-i];
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial CRC16 (x^16+x^15+x^2+1), one data bit per enabled clock.
module usb_crc16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] rem
);

  // Galois-style MSB-first shift; bits arrive in line order.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst)    rem <= CRC_INIT;
    else if (clr) rem <= CRC_INIT;
    else if (en)  rem <= {rem[14:0], 1'b0} ^ ((din ^ rem[15]) ? CRC_POLY : 16'h0000);
  end

endmodule

// File: rtl/usb_tx.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, EOP with
// bit stuffing and NRZI, eight clocks per bit.
module usb_tx
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [1:0] tx_packet,
  input  logic [7:0] tx_packet_data,
  input  logic [6:0] tx_packet_data_size,
  output logic       dPlus_out,
  output logic       dMinus_out,
  output logic       tx_done,
  output logic       get_tx_packet
);

  tx_state_t          state;
  tx_cmd_t            cmd;
  logic [PHASE_W-1:0] phase;      // clock within the current bit time
  logic [3:0]         bit_idx;    // bit within byte (0..7) or CRC (0..15)
  logic [6:0]         byte_cnt;   // payload bytes loaded so far
  logic [15:0]        sh;         // outgoing bits, LSB first
  logic [2:0]         ones;       // consecutive 1s sent, pre-NRZI
  logic               stuff;      // current bit time is a stuffed 0
  logic               line;       // NRZI line level, 1 = J
  logic [15:0]        crc_rem;

  logic       bit_start, bit_end, sending, stuffable, cur_bit, nrzi_next;
  logic       last_bit, need_stuff, more_bytes, fetch_pulse, crc_en, crc_clr;
  logic [6:0] size_c;

  assign bit_start  = (phase == '0);
  assign bit_end    = (phase == PHASE_W'(CLKS_PER_BIT - 1));
  assign sending    = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC};
  assign stuffable  = state inside {ST_PID, ST_DATA, ST_CRC};
  assign cur_bit    = stuff ? 1'b0 : sh[0];
  assign nrzi_next  = cur_bit ? line : ~line;
  assign last_bit   = (state == ST_CRC) ? (bit_idx == 4'd15) : (bit_idx == 4'd7);
  assign need_stuff = stuffable && !stuff && (ones == 3'(STUFF_RUN));
  assign more_bytes = ((state == ST_PID) && (cmd.pkt == CMD_DATA) && (cmd.size != '0)) ||
                      ((state == ST_DATA) && (byte_cnt != cmd.size));
  // Request the next byte as the last data bit of the current byte goes out.
  assign fetch_pulse = bit_start && !stuff && (bit_idx == 4'd7) && more_bytes;
  assign crc_en      = bit_start && !stuff && (state == ST_DATA);
  assign crc_clr     = (state == ST_IDLE);
  assign size_c      = (tx_packet_data_size > 7'(MAX_BYTES)) ? 7'(MAX_BYTES)
                                                             : tx_packet_data_size;

  usb_crc16 u_crc (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (sh[0]),
    .rem   (crc_rem)
  );

  // Packet FSM: bit timer, serializer, stuffer, NRZI and registered outputs.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state         <= ST_IDLE;
      cmd           <= '0;
      phase         <= '0;
      bit_idx       <= '0;
      byte_cnt      <= '0;
      sh            <= '0;
      ones          <= '0;
      stuff         <= 1'b0;
      line          <= 1'b1;
      dPlus_out     <= 1'b1;
      dMinus_out    <= 1'b0;
      tx_done       <= 1'b0;
      get_tx_packet <= 1'b0;
    end else begin
      tx_done       <= 1'b0;
      get_tx_packet <= fetch_pulse;
      case (state)
        ST_IDLE: begin
          if (tx_packet != CMD_IDLE) begin
            cmd     <= tx_cmd_t'{pkt: tx_packet, size: size_c};
            state   <= ST_SYNC;
            sh      <= {8'h00, SYNC_BYTE};
            bit_idx <= '0;
            phase   <= '0;
            ones    <= '0;
            stuff   <= 1'b0;
          end
        end
        ST_REARM: begin
          // A held command must drop back to IDLE before another packet.
          if (tx_packet == CMD_IDLE) state <= ST_IDLE;
        end
        default: begin
          phase <= phase + 1'b1;
          if (bit_start) begin
            if (sending) begin
              line       <= nrzi_next;
              dPlus_out  <= nrzi_next;
              dMinus_out <= ~nrzi_next;
              ones       <= cur_bit ? ones + 3'd1 : 3'd0;
            end else if (state == ST_EOP_SE0) begin
              dPlus_out  <= 1'b0;
              dMinus_out <= 1'b0;
            end else begin
              line       <= 1'b1;
              dPlus_out  <= 1'b1;
              dMinus_out <= 1'b0;
            end
          end
          if (bit_end) begin
            if (need_stuff) begin
              // Insert a 0 and hold the pending data bit for one more slot.
              stuff <= 1'b1;
            end else begin
              stuff <= 1'b0;
              case (state)
                ST_SYNC: begin
                  if (last_bit) begin
                    state   <= ST_PID;
                    sh      <= {8'h00, pid_for(cmd.pkt)};
                    bit_idx <= '0;
                  end else begin
                    sh      <= {1'b0, sh[15:1]};
                    bit_idx <= bit_idx + 4'd1;
                  end
                end
                ST_PID: begin
                  if (last_bit) begin
                    bit_idx <= '0;
                    if (cmd.pkt != CMD_DATA) begin
                      state <= ST_EOP_SE0;
                    end else if (cmd.size != '0) begin
                      state    <= ST_DATA;
                      sh       <= {8'h00, tx_packet_data};
                      byte_cnt <= 7'd1;
                    end else begin
                      state <= ST_CRC;
                      sh    <= crc_tx_bits(crc_rem);
                    end
                  end else begin
                    sh      <= {1'b0, sh[15:1]};
                    bit_idx <= bit_idx + 4'd1;
                  end
                end
                ST_DATA: begin
                  if (last_bit) begin
                    bit_idx <= '0;
                    if (byte_cnt == cmd.size) begin
                      state <= ST_CRC;
                      sh    <= crc_tx_bits(crc_rem);
                    end else begin
                      sh       <= {8'h00, tx_packet_data};
                      byte_cnt <= byte_cnt + 7'd1;
                    end
                  end else begin
                    sh      <= {1'b0, sh[15:1]};
                    bit_idx <= bit_idx + 4'd1;
                  end
                end
                ST_CRC: begin
                  if (last_bit) begin
                    state   <= ST_EOP_SE0;
                    bit_idx <= '0;
                  end else begin
                    sh      <= {1'b0, sh[15:1]};
                    bit_idx <= bit_idx + 4'd1;
                  end
                end
                ST_EOP_SE0: begin
                  if (bit_idx == 4'd1) begin
                    state   <= ST_EOP_J;
                    bit_idx <= '0;
                  end else begin
                    bit_idx <= bit_idx + 4'd1;
                  end
                end
                ST_EOP_J: begin
                  state   <= ST_REARM;
                  tx_done <= 1'b1;
                end
                default: state <= ST_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_tx.sv
// Scoreboard bench for usb_tx: expected line symbols are queued per packet
// and a monitor compares D+/D-, get_tx_packet and tx_done every clock.
module tb_usb_tx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic [1:0] tx_packet = 2'b00;
  logic [7:0] tx_packet_data = 8'h00;
  logic [6:0] tx_packet_data_size = 7'd0;
  logic       dPlus_out, dMinus_out, tx_done, get_tx_packet;

  usb_tx dut (
    .clk                 (clk),
    .n_rst               (n_rst),
    .tx_packet           (tx_packet),
    .tx_packet_data      (tx_packet_data),
    .tx_packet_data_size (tx_packet_data_size),
    .dPlus_out           (dPlus_out),
    .dMinus_out          (dMinus_out),
    .tx_done             (tx_done),
    .get_tx_packet       (get_tx_packet)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic dp;
    logic dm;
    logic get;   // get_tx_packet high on first clock of this bit
    logic done;  // tx_done high on last clock of this bit
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  bit         mon_busy = 1'b0;
  logic [7:0] pay[$];
  int         pkt_id = 0;
  int         gcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected bit-time symbols: SYNC, PID, payload, CRC bytes LSB first,
  // with stuffing and NRZI applied, then SE0 SE0 J.
  task automatic push_pkt(input logic [7:0] pid, input logic [15:0] crc, input bit is_data);
    logic [7:0] bytes[$];
    logic [7:0] cb;
    logic       ln, b;
    int         ones;
    exp_t       e;
    bytes.push_back(8'h80);
    bytes.push_back(pid);
    if (is_data) begin
      foreach (pay[j]) bytes.push_back(pay[j]);
      bytes.push_back(crc[7:0]);
      bytes.push_back(crc[15:8]);
    end
    ln = 1'b1;
    ones = 0;
    for (int k = 0; k < bytes.size(); k++) begin
      cb = bytes[k];
      for (int i = 0; i < 8; i++) begin
        b = cb[i];
        ln = b ? ln : ~ln;
        ones = b ? ones + 1 : 0;
        e.dp = ln; e.dm = ~ln; e.done = 1'b0;
        e.get = is_data && (i == 7) && (k >= 1) && ((k - 1) < pay.size());
        exp_q.push_back(e);
        if (k >= 1 && ones == 6) begin
          ln = ~ln;
          ones = 0;
          e.dp = ln; e.dm = ~ln; e.get = 1'b0; e.done = 1'b0;
          exp_q.push_back(e);
        end
      end
    end
    e = '0;
    exp_q.push_back(e);
    exp_q.push_back(e);
    e.dp = 1'b1; e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: once a packet is expected, start on the first K and compare
  // every clock of every queued bit time.
  initial begin
    exp_t e;
    bit   first;
    int   idx;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0 && dPlus_out === 1'b0 && dMinus_out === 1'b1) begin
        mon_busy = 1'b1;
        first = 1'b1;
        idx = 0;
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          for (int c = 0; c < 8; c++) begin
            if (!first) @(negedge clk);
            first = 1'b0;
            check($sformatf("line bit%0d clk%0d {dp,dm,get,done}", idx, c),
                  {28'h0, dPlus_out, dMinus_out, get_tx_packet, tx_done},
                  {28'h0, e.dp, e.dm, e.get && (c == 0), e.done && (c == 7)});
          end
          idx++;
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Data buffer model: serve the next payload byte after each request.
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (pkt_id != seen) begin
        seen = pkt_id;
        gcnt = 0;
      end
      if (get_tx_packet === 1'b1) begin
        tx_packet_data = (gcnt < pay.size()) ? pay[gcnt] : 8'hEE;
        gcnt++;
      end
    end
  end

  task automatic start_pkt(input logic [1:0] c, input int size, input bit chk,
                           input logic [7:0] pid, input logic [15:0] crc);
    @(negedge clk);
    pkt_id++;
    tx_packet_data_size = 7'(size);
    if (chk) push_pkt(pid, crc, c == 2'b01);
    tx_packet = c;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 4000) begin
      @(posedge clk);
      n++;
    end
    check({name, " completes in time"}, (n < 4000) ? 32'd1 : 32'd0, 32'd1);
    if (n >= 4000) exp_q.delete();
  endtask

  task automatic release_cmd();
    @(negedge clk);
    tx_packet = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_123456789();
    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    int bad;
    int n;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset {dp,dm,done,get}", {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
    n_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({dPlus_out, dMinus_out, tx_done, get_tx_packet} !== 4'b1000) bad++;
    end
    check("idle hold bad clocks", bad, 0);

    // ACK: start latency, then full line pattern; command drop mid-packet ignored
    pay.delete();
    start_pkt(2'b10, 0, 1'b1, 8'hD2, 16'h0000);
    @(posedge clk); #1;
    check("ack dp at edge k", dPlus_out, 1'b1);
    @(posedge clk); #1;
    check("ack dp at edge k+1", dPlus_out, 1'b0);
    tx_packet = 2'b00;
    drain("ack");
    check("ack get pulses", gcnt, 0);
    repeat (3) @(negedge clk);

    // NAK held after completion: no retransmit
    start_pkt(2'b11, 0, 1'b1, 8'h5A, 16'h0000);
    drain("nak");
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dPlus_out !== 1'b1 || dMinus_out !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("nak held no retransmit", bad, 0);
    release_cmd();

    // DATA "123456789": CRC bytes C8, B4
    load_123456789();
    start_pkt(2'b01, 9, 1'b1, 8'hC3, 16'hB4C8);
    drain("data9");
    check("data9 get pulses", gcnt, 9);
    release_cmd();

    // DATA 0xFF: stuffed bit after 4th payload bit; CRC 00 FF also stuffs
    pay.delete();
    pay.push_back(8'hFF);
    start_pkt(2'b01, 1, 1'b1, 8'hC3, 16'hFF00);
    drain("data1 ff");
    check("data1 get pulses", gcnt, 1);
    release_cmd();

    // DATA size 0: PID then CRC 0000
    pay.delete();
    start_pkt(2'b01, 0, 1'b1, 8'hC3, 16'h0000);
    drain("data0");
    check("data0 get pulses", gcnt, 0);
    release_cmd();

    // Oversize length clamps to 64 bytes
    pay.delete();
    start_pkt(2'b01, 100, 1'b0, 8'hC3, 16'h0000);
    n = 0;
    while (tx_done !== 1'b1 && n < 8000) begin
      @(posedge clk); #1;
      n++;
    end
    check("size100 done seen", (n < 8000) ? 32'd1 : 32'd0, 32'd1);
    check("size100 get pulses", gcnt, 64);
    release_cmd();

    // Reset mid-payload aborts to J, no tx_done
    load_123456789();
    start_pkt(2'b01, 9, 1'b0, 8'hC3, 16'h0000);
    repeat (200) @(negedge clk);
    n_rst = 1'b1;
    #1;
    check("abort {dp,dm,done,get}", {dPlus_out, dMinus_out, tx_done, get_tx_packet}, 4'b1000);
    tx_packet = 2'b00;
    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_done !== 1'b0 || dPlus_out !== 1'b1) bad++;
    end
    check("abort quiet after reset", bad, 0);

    // Fresh DATA after abort
    load_123456789();
    start_pkt(2'b01, 9, 1'b1, 8'hC3, 16'hB4C8);
    drain("data9 after reset");
    check("data9 after reset get pulses", gcnt, 9);
    release_cmd();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
